// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM encoding, PRBS seed and step.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam logic [6:0] PRBS_SEED = 7'h7F;
  localparam logic [3:0] ONES_MAX  = 4'd15;

  // Fibonacci step for x^7 + x^6 + 1; the bit leaving on dout is s[6].
  function automatic logic [6:0] prbs_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

endpackage

// File: rtl/seq_tx_lfsr.sv
// 7-bit PRBS source for seq_pattern_tx; only built when SEQ_TX_PRBS_EN is defined.
// bit_o already reflects the seed in the cycle seed_i is high, so the first bit needs no extra latency.
`ifdef SEQ_TX_PRBS_EN
module seq_tx_lfsr
  import seq_tx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic seed_i,
  input  logic en_i,
  output logic bit_o
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;
  logic [6:0] cur;

  assign cur    = seed_i ? PRBS_SEED : lfsr_q;
  assign bit_o  = cur[6];
  assign lfsr_d = en_i ? prbs_step(cur) : cur;

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= PRBS_SEED;
    else     lfsr_q <= lfsr_d;
  end

endmodule
`endif

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: loads a parallel frame and sends it MSB-first with repeats and idle gaps.
// Optional PRBS frame source is enabled with macro SEQ_TX_PRBS_EN.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2,
  parameter int RPT_W      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [WIDTH-1:0]         data,
  input  logic [RPT_W-1:0]         rpt,
`ifdef SEQ_TX_PRBS_EN
  input  logic                     prbs_sel,
`endif
  output logic                     ready,
  output logic                     dout,
  output logic                     dout_valid,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic [3:0]               ones_cnt,
  output logic                     done
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic b);
    return (b && (v != ONES_MAX)) ? v + 4'd1 : v;
  endfunction

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   frame_q, frame_d;
  logic [RPT_W-1:0]   reps_q, reps_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         ones_q, ones_d;
  logic               ready_q, ready_d;
  logic               dout_q, dout_d;
  logic               vld_q, vld_d;
  logic               done_q, done_d;
  logic               accept, emit, clear, src_bit;

  assign accept = load & ready_q;

`ifdef SEQ_TX_PRBS_EN
  logic prbs_q, prbs_d, lfsr_bit, lfsr_en;

  assign lfsr_en = emit & prbs_d;

  seq_tx_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .seed_i (accept & prbs_sel),
    .en_i   (lfsr_en),
    .bit_o  (lfsr_bit)
  );
`endif

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    reps_d  = reps_q;
    gap_d   = gap_q;
    idx_d   = '0;
    ready_d = 1'b0;
    done_d  = 1'b0;
    emit    = 1'b0;
    clear   = 1'b0;
`ifdef SEQ_TX_PRBS_EN
    prbs_d  = prbs_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          state_d = ST_SHIFT;
          frame_d = data;
          reps_d  = rpt;
          ready_d = 1'b0;
          emit    = 1'b1;
          clear   = 1'b1;
          idx_d   = IDX_W'(WIDTH - 1);
`ifdef SEQ_TX_PRBS_EN
          prbs_d  = prbs_sel;
`endif
        end
      end
      ST_SHIFT: begin
        if (idx_q != '0) begin
          emit  = 1'b1;
          idx_d = idx_q - IDX_W'(1);
        end else if (reps_q != '0) begin
          reps_d = reps_q - RPT_W'(1);
          if (GAP_CYCLES == 0) begin
            emit  = 1'b1;
            clear = 1'b1;
            idx_d = IDX_W'(WIDTH - 1);
          end else begin
            state_d = ST_GAP;
            gap_d   = GAP_W'(GAP_CYCLES - 1);
          end
        end else begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_SHIFT;
          emit    = 1'b1;
          clear   = 1'b1;
          idx_d   = IDX_W'(WIDTH - 1);
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase

    // Bit for the next cycle comes from the frame being captured or the held frame.
`ifdef SEQ_TX_PRBS_EN
    src_bit = prbs_d ? lfsr_bit : frame_d[idx_d];
`else
    src_bit = frame_d[idx_d];
`endif
    vld_d  = emit;
    dout_d = emit & src_bit;
    ones_d = ones_q;
    if (emit) ones_d = sat_inc(clear ? 4'd0 : ones_q, src_bit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      reps_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      ones_q  <= '0;
      ready_q <= 1'b1;
      dout_q  <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_TX_PRBS_EN
      prbs_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      reps_q  <= reps_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      ones_q  <= ones_d;
      ready_q <= ready_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
`ifdef SEQ_TX_PRBS_EN
      prbs_q  <= prbs_d;
`endif
    end
  end

  // Frame contents are only meaningful while busy, so they carry no reset.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  assign ready      = ready_q;
  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign bit_idx    = idx_q;
  assign ones_cnt   = ones_q;
  assign done       = done_q;

endmodule
